// File: rtl/car_sensor_frontend.sv
// Vehicle-loop detector conditioning: per-road sync, debounce, request latch and
// stuck-high detection, producing the car_h/car_c request levels for light_control.

module car_sensor_channel #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STUCK_CYCLES    = 200
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       det_raw,
    input  logic [1:0] road,
    output logic       car,
    output logic       stuck
);
    localparam logic [1:0] GREEN = 2'b10;
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int SW = $clog2(STUCK_CYCLES);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SW-1:0] ST_LAST = SW'(STUCK_CYCLES - 1);

    logic [1:0]    sync_pipe;
    logic          filt;
    logic [DW-1:0] cnt;
    logic [SW-1:0] scnt;

    // Two-flop synchronizer; sync_pipe[1] is the clean sample.
    always_ff @(posedge clk) begin
        if (clear) sync_pipe <= '0;
        else       sync_pipe <= {sync_pipe[0], det_raw};
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            filt <= 1'b0;
            cnt  <= '0;
        end else if (sync_pipe[1] == filt) begin
            cnt <= '0;
        end else if (cnt == DB_LAST) begin
            filt <= sync_pipe[1];
            cnt  <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // scnt saturates at its terminal value so it never wraps on a long press.
    always_ff @(posedge clk) begin
        if (clear) begin
            scnt  <= '0;
            stuck <= 1'b0;
        end else if (!filt) begin
            scnt <= '0;
        end else begin
            if (scnt != ST_LAST) scnt <= scnt + 1'b1;
            if (scnt == ST_LAST) stuck <= 1'b1;
        end
    end

    // A request is only retired by its road's GREEN; a stuck detector pins it high.
    always_ff @(posedge clk) begin
        if (clear)                car <= 1'b0;
        else if (stuck || filt)   car <= 1'b1;
        else if (road == GREEN)   car <= 1'b0;
    end
endmodule

module car_sensor_frontend #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STUCK_CYCLES    = 200
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       det_h_raw,
    input  logic       det_c_raw,
    input  logic [1:0] hwy,
    input  logic [1:0] cntry,
    output logic       car_h,
    output logic       car_c,
    output logic       stuck_h,
    output logic       stuck_c
);
    localparam int NUM_LANES = 2;

    logic [NUM_LANES-1:0]       det_raw;
    logic [NUM_LANES-1:0][1:0]  road;
    logic [NUM_LANES-1:0]       car;
    logic [NUM_LANES-1:0]       stuck;

    // Lane 0 is highway, lane 1 is country.
    assign det_raw = {det_c_raw, det_h_raw};
    assign road    = {cntry, hwy};

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        car_sensor_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .STUCK_CYCLES    (STUCK_CYCLES)
        ) u_ch (
            .clk     (clk),
            .clear   (clear),
            .det_raw (det_raw[g]),
            .road    (road[g]),
            .car     (car[g]),
            .stuck   (stuck[g])
        );
    end

    assign car_h   = car[0];
    assign car_c   = car[1];
    assign stuck_h = stuck[0];
    assign stuck_c = stuck[1];
endmodule

// File: tb/tb_car_sensor_frontend.sv
// Self-checking bench for car_sensor_frontend: directed scenarios plus randomized
// traffic, all compared against a run-length behavioural model of each road.

module tb_car_sensor_frontend;
    localparam int D = 4;
    localparam int S = 20;
    localparam logic [1:0] RED = 2'b00, GREEN = 2'b10, ILL = 2'b11;

    logic clk = 1'b0;
    logic clear = 1'b1;
    logic det_h_raw = 1'b0, det_c_raw = 1'b0;
    logic [1:0] hwy = RED, cntry = RED;
    logic car_h, car_c, stuck_h, stuck_c;

    int checks = 0;
    int errors = 0;

    car_sensor_frontend #(.DEBOUNCE_CYCLES(D), .STUCK_CYCLES(S)) dut (
        .clk(clk), .clear(clear), .det_h_raw(det_h_raw), .det_c_raw(det_c_raw),
        .hwy(hwy), .cntry(cntry), .car_h(car_h), .car_c(car_c),
        .stuck_h(stuck_h), .stuck_c(stuck_c)
    );

    always #5 clk = ~clk;

    // Reference model, index 0 = highway, 1 = country. Raw is seen two edges late;
    // the level flips after D consecutive disagreeing samples; a detector is stuck
    // once the level has been high for S consecutive edges.
    bit m_d1[2], m_d2[2], m_filt[2], m_car[2], m_stuck[2];
    int m_run[2], m_hi[2];
    logic [3:0] dut_out, m_out;
    assign dut_out = {car_h, car_c, stuck_h, stuck_c};
    assign m_out   = {m_car[0], m_car[1], m_stuck[0], m_stuck[1]};

    always @(posedge clk) begin
        bit raw[2];
        logic [1:0] rd[2];
        raw[0] = det_h_raw; raw[1] = det_c_raw;
        rd[0] = hwy; rd[1] = cntry;
        for (int k = 0; k < 2; k++) begin
            if (clear) begin
                m_d1[k] = 0; m_d2[k] = 0; m_filt[k] = 0; m_car[k] = 0;
                m_stuck[k] = 0; m_run[k] = 0; m_hi[k] = 0;
            end else begin
                if (m_stuck[k] || m_filt[k]) m_car[k] = 1;
                else if (rd[k] == GREEN)     m_car[k] = 0;
                if (m_filt[k]) begin
                    m_hi[k]++;
                    if (m_hi[k] >= S) m_stuck[k] = 1;
                end else m_hi[k] = 0;
                if (m_d2[k] != m_filt[k]) begin
                    m_run[k]++;
                    if (m_run[k] == D) begin m_filt[k] = m_d2[k]; m_run[k] = 0; end
                end else m_run[k] = 0;
                m_d2[k] = m_d1[k];
                m_d1[k] = raw[k];
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_clear();
        clear = 1'b1; det_h_raw = 0; det_c_raw = 0; hwy = RED; cntry = RED;
        cyc(); cyc();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        int rise;
        clear = 1'b1; det_h_raw = 1; det_c_raw = 1; hwy = RED; cntry = RED;
        for (int e = 1; e <= 3; e++) begin
            cyc();
            checks++;
            if (dut_out !== 4'b0000) begin
                errors++; $display("FAIL reset edge %0d: got %b exp 0000", e, dut_out);
            end
        end
        clear = 1'b0;
        rise = 0;
        for (int e = 1; e <= 10; e++) begin
            cyc();
            checks++;
            if (dut_out !== m_out) begin
                errors++; $display("FAIL reset_rel edge %0d: got %b exp %b", e, dut_out, m_out);
            end
            if (car_c === 1'b1 && rise == 0) rise = e;
        end
        checks++;
        if (rise !== 7) begin
            errors++; $display("FAIL reset_latency: car_c rose at edge %0d exp 7", rise);
        end
    endtask

    task automatic test_glitch();
        int rise;
        do_clear();
        for (int e = 1; e <= 12; e++) begin
            det_c_raw = (e <= 3);
            cyc();
            checks++;
            if (car_c !== 1'b0 || dut_out !== m_out) begin
                errors++; $display("FAIL glitch edge %0d: got %b exp %b", e, dut_out, m_out);
            end
        end
        rise = 0;
        for (int e = 1; e <= 12; e++) begin
            det_c_raw = (e <= 4);
            cyc();
            checks++;
            if (dut_out !== m_out) begin
                errors++; $display("FAIL pulse4 edge %0d: got %b exp %b", e, dut_out, m_out);
            end
            if (car_c === 1'b1 && rise == 0) rise = e;
        end
        checks++;
        if (rise !== 7) begin
            errors++; $display("FAIL pulse4_latency: car_c rose at edge %0d exp 7", rise);
        end
    endtask

    task automatic test_latch_retire();
        int fall;
        do_clear();
        for (int e = 1; e <= 30; e++) begin
            det_c_raw = (e <= 6);
            cyc();
            checks++;
            if (dut_out !== m_out) begin
                errors++; $display("FAIL latch edge %0d: got %b exp %b", e, dut_out, m_out);
            end
        end
        checks++;
        if (car_c !== 1'b1) begin
            errors++; $display("FAIL latch_hold: car_c=%b exp 1", car_c);
        end
        cntry = GREEN;
        cyc();
        checks++;
        if (car_c !== 1'b0) begin
            errors++; $display("FAIL retire: car_c=%b exp 0", car_c);
        end
        // Vehicle still present while green: request must persist until level falls.
        do_clear();
        det_c_raw = 1;
        for (int e = 1; e <= 10; e++) cyc();
        cntry = GREEN;
        for (int e = 1; e <= 5; e++) begin
            cyc();
            checks++;
            if (car_c !== 1'b1) begin
                errors++; $display("FAIL green_hold edge %0d: car_c=%b exp 1", e, car_c);
            end
        end
        det_c_raw = 0;
        fall = 0;
        for (int e = 1; e <= 10; e++) begin
            cyc();
            checks++;
            if (dut_out !== m_out) begin
                errors++; $display("FAIL green_fall edge %0d: got %b exp %b", e, dut_out, m_out);
            end
            if (car_c === 1'b0 && fall == 0) fall = e;
        end
        checks++;
        if (fall !== 7) begin
            errors++; $display("FAIL fall_latency: car_c fell at edge %0d exp 7", fall);
        end
    endtask

    task automatic test_stuck();
        int st;
        do_clear();
        det_h_raw = 1;
        st = 0;
        for (int e = 1; e <= 40; e++) begin
            cyc();
            checks++;
            if (dut_out !== m_out) begin
                errors++; $display("FAIL stuck edge %0d: got %b exp %b", e, dut_out, m_out);
            end
            if (stuck_h === 1'b1 && st == 0) st = e;
        end
        checks++;
        if (st < 24 || st > 28) begin
            errors++; $display("FAIL stuck_time: stuck_h at edge %0d exp about 26", st);
        end
        det_h_raw = 0; hwy = GREEN;
        for (int e = 1; e <= 25; e++) begin
            cyc();
            checks++;
            if (car_h !== 1'b1 || stuck_h !== 1'b1 || stuck_c !== 1'b0) begin
                errors++; $display("FAIL stuck_sticky edge %0d: got %b exp car_h=1 stuck_h=1", e, dut_out);
            end
        end
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        checks++;
        if (dut_out !== 4'b0000) begin
            errors++; $display("FAIL stuck_clear: got %b exp 0000", dut_out);
        end
    endtask

    task automatic test_illegal();
        do_clear();
        for (int e = 1; e <= 15; e++) begin
            det_h_raw = (e <= 5);
            cyc();
        end
        hwy = ILL;
        for (int e = 1; e <= 10; e++) begin
            cyc();
            checks++;
            if (car_h !== 1'b1) begin
                errors++; $display("FAIL illegal edge %0d: car_h=%b exp 1", e, car_h);
            end
        end
        hwy = GREEN;
        cyc();
        checks++;
        if (car_h !== 1'b0) begin
            errors++; $display("FAIL illegal_then_green: car_h=%b exp 0", car_h);
        end
    endtask

    task automatic test_mid_reset();
        int rise;
        do_clear();
        det_c_raw = 1;
        for (int e = 1; e <= 4; e++) cyc();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        checks++;
        if (dut_out !== 4'b0000) begin
            errors++; $display("FAIL mid_debounce_clear: got %b exp 0000", dut_out);
        end
        rise = 0;
        for (int e = 1; e <= 10; e++) begin
            cyc();
            if (car_c === 1'b1 && rise == 0) rise = e;
        end
        checks++;
        if (rise !== 7) begin
            errors++; $display("FAIL mid_reset_latency: car_c rose at edge %0d exp 7", rise);
        end
        do_clear();
        for (int e = 1; e <= 15; e++) begin
            det_h_raw = (e <= 5);
            cyc();
        end
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        checks++;
        if (dut_out !== 4'b0000) begin
            errors++; $display("FAIL mid_request_clear: got %b exp 0000", dut_out);
        end
        for (int e = 1; e <= 8; e++) begin
            cyc();
            checks++;
            if (dut_out !== m_out) begin
                errors++; $display("FAIL post_clear edge %0d: got %b exp %b", e, dut_out, m_out);
            end
        end
    endtask

    task automatic test_random();
        do_clear();
        for (int e = 1; e <= 800; e++) begin
            if ($urandom_range(5) == 0) det_h_raw = ~det_h_raw;
            if ($urandom_range(5) == 0) det_c_raw = ~det_c_raw;
            if ($urandom_range(7) == 0) hwy = 2'($urandom_range(3));
            if ($urandom_range(7) == 0) cntry = 2'($urandom_range(3));
            clear = ($urandom_range(150) == 0);
            cyc();
            checks++;
            if (dut_out !== m_out) begin
                errors++; $display("FAIL random edge %0d: got %b exp %b", e, dut_out, m_out);
            end
        end
        clear = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_glitch();
        test_latch_retire();
        test_stuck();
        test_illegal();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
